// File: rtl/i2c_write_sequencer.sv
// rtl/i2c_write_sequencer.sv - I2C write sequencer driving a parallel-to-serial datapath
//
// Purpose: per accepted start request, emits START, address byte {dev_addr,0},
// two data bytes serialised by the PTS block (byte select 0 then 1), and STOP.
// The slave ACK is checked after every byte; a NACK sets ack_err and jumps to STOP.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           transfer request, only honoured in IDLE
//   dev_addr        7-bit slave address, latched on start acceptance
//   pts_ser_in      serial bit from PTS (valid while pts_en=1)
//   sda_in          SDA pad input, used for ACK sampling
//   pts_en          PTS enable, high during data-bit phases only
//   pts_cycle       PTS byte select (0 = first data byte, 1 = second)
//   pts_counter     PTS bit index, 0 = first bit on the wire
//   scl_out         SCL level (1 = released)
//   sda_oe          1 = pull SDA low, 0 = release
//   busy            high from start acceptance until done
//   done            one-clk pulse after STOP completes
//   ack_err         sticky NACK flag, cleared on next accepted start

module i2c_write_sequencer #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic       pts_ser_in,
  input  logic       sda_in,
  output logic       pts_en,
  output logic       pts_cycle,
  output logic [2:0] pts_counter,
  output logic       scl_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA0, S_ACK0, S_DATA1, S_ACK1, S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bit_q, bit_d;
  logic        cyc_q, cyc_d;
  logic [6:0]  addr_q, addr_d;
  logic        ack_err_q, ack_err_d;
  logic        done_q, done_d;

  logic        tick;
  logic        phase_end;
  logic [7:0]  addr_byte;

  assign tick      = (qcnt_q == QW'(CLK_DIV - 1));
  assign phase_end = tick && (quarter_q == 2'd3);
  assign addr_byte = {addr_q, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      cyc_q     <= 1'b0;
      addr_q    <= 7'd0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      cyc_q     <= cyc_d;
      addr_q    <= addr_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  // Next-state: the quarter counter free-runs outside IDLE; phase transitions
  // happen only on the last clk of q3, which is also where ACK is sampled.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = tick ? '0 : qcnt_q + QW'(1);
    quarter_d = tick ? quarter_q + 2'd1 : quarter_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        qcnt_d    = '0;
        quarter_d = 2'd0;
        if (start) begin
          state_d   = S_START;
          addr_d    = dev_addr;
          ack_err_d = 1'b0;
        end
      end
      S_START: if (phase_end) state_d = S_ADDR;
      S_ADDR, S_DATA0, S_DATA1: begin
        if (phase_end) begin
          bit_d = bit_q + 3'd1;  // wraps 7->0 as the ACK phase begins
          if (bit_q == 3'd7) begin
            case (state_q)
              S_ADDR:  state_d = S_ADDR_ACK;
              S_DATA0: state_d = S_ACK0;
              default: state_d = S_ACK1;
            endcase
          end
        end
      end
      S_ADDR_ACK, S_ACK0, S_ACK1: begin
        if (phase_end) begin
          if (sda_in) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            case (state_q)
              S_ADDR_ACK: state_d = S_DATA0;
              S_ACK0: begin
                state_d = S_DATA1;
                cyc_d   = 1'b1;
              end
              default: state_d = S_STOP;
            endcase
          end
        end
      end
      S_STOP: begin
        if (phase_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cyc_d   = 1'b0;
          bit_d   = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus levels decode from registered state only (plus the PTS bit, which is
  // held stable by pts_counter for the whole bit phase).
  always_comb begin
    scl_out = 1'b1;
    sda_oe  = 1'b0;
    pts_en  = 1'b0;
    case (state_q)
      S_START: sda_oe = quarter_q[1];
      S_ADDR: begin
        scl_out = quarter_q[1];
        sda_oe  = ~addr_byte[3'd7 - bit_q];
      end
      S_DATA0, S_DATA1: begin
        scl_out = quarter_q[1];
        pts_en  = 1'b1;
        sda_oe  = ~pts_ser_in;
      end
      S_ADDR_ACK, S_ACK0, S_ACK1: scl_out = quarter_q[1];
      S_STOP: begin
        scl_out = (quarter_q != 2'd0);
        sda_oe  = ~quarter_q[1];
      end
      default: ;
    endcase
  end

  assign pts_cycle   = cyc_q;
  assign pts_counter = bit_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb/tb_i2c_write_sequencer.sv - directed self-checking bench for i2c_write_sequencer
module tb_i2c_write_sequencer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] dev_addr;
  wire        pts_ser_in;
  wire        sda_in;
  logic       pts_en, pts_cycle, scl_out, sda_oe, busy, done, ack_err;
  logic [2:0] pts_counter;

  logic [7:0] pts_b0, pts_b1;
  logic [2:0] ack_mask;
  logic       slave_pull;
  logic       mon_clr;

  int total = 0;
  int bad   = 0;

  // monitor state
  logic       scl_prev, sda_prev, bus;
  logic [7:0] sh;
  logic [2:0] last_cnt;
  int         bitn, starts, stops, done_cnt, pe_cnt, seq_err;
  logic       cyc1_seen;
  logic [7:0] bytes_q[$];

  i2c_write_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr),
    .pts_ser_in(pts_ser_in), .sda_in(sda_in), .pts_en(pts_en),
    .pts_cycle(pts_cycle), .pts_counter(pts_counter), .scl_out(scl_out),
    .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  assign pts_ser_in = pts_en ? (pts_cycle ? pts_b1[3'd7 - pts_counter]
                                          : pts_b0[3'd7 - pts_counter]) : 1'bz;
  assign sda_in = ~sda_oe & ~slave_pull;

  // Bus monitor and ACKing slave, sampled on the inactive edge.
  always @(negedge clk) begin
    if (mon_clr || rst) begin
      scl_prev = 1'b1; sda_prev = 1'b1; slave_pull = 1'b0; last_cnt = 3'd7;
      bitn = 0; starts = 0; stops = 0; done_cnt = 0; pe_cnt = 0; seq_err = 0;
      cyc1_seen = 1'b0; sh = 8'd0;
      bytes_q.delete();
    end else begin
      bus = sda_in;
      if (done) done_cnt++;
      if (pts_en) begin
        pe_cnt++;
        if (pts_cycle) cyc1_seen = 1'b1;
        if (pts_counter != last_cnt) begin
          if (pts_counter != last_cnt + 3'd1) seq_err++;
          last_cnt = pts_counter;
        end
      end else begin
        last_cnt = 3'd7;
      end
      if (scl_prev && scl_out && sda_prev && !bus) begin
        starts++;
        bitn = 0;
      end
      if (scl_prev && scl_out && !sda_prev && bus) stops++;
      if (!scl_prev && scl_out) begin
        sh = {sh[6:0], bus};
        if (bitn % 9 == 7) bytes_q.push_back(sh);
        bitn++;
      end
      if (scl_prev && !scl_out)
        slave_pull = (bitn % 9 == 8) && (bitn / 9 < 3) && ack_mask[bitn / 9];
      scl_prev = scl_out;
      sda_prev = bus;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Issue one start and wait (bounded) for done; optionally re-pulse start mid-transfer.
  task automatic run_xfer(input logic [6:0] a, input logic [2:0] acks,
                          input int pulse_at, output int lat);
    ack_mask = acks;
    clear_mon();
    dev_addr = a;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
      start = (lat == pulse_at);
      if (lat == pulse_at) dev_addr = 7'h11;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  int lat;

  initial begin
    rst = 1'b1; start = 1'b0; dev_addr = 7'd0; mon_clr = 1'b0;
    pts_b0 = 8'h5A; pts_b1 = 8'hA5; ack_mask = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl_out, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_pts_en", pts_en, 0);
    chk("rst_pts_cycle", pts_cycle, 0);
    chk("rst_pts_counter", pts_counter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // full write
    run_xfer(7'h50, 3'b111, -1, lat);
    chk("full_latency", lat, 464);
    chk("full_nbytes", bytes_q.size(), 3);
    if (bytes_q.size() == 3) begin
      chk("full_byte0", bytes_q[0], 8'hA0);
      chk("full_byte1", bytes_q[1], 8'h5A);
      chk("full_byte2", bytes_q[2], 8'hA5);
    end
    chk("full_ack_err", ack_err, 0);
    chk("full_pts_en_clks", pe_cnt, 256);
    chk("full_cnt_seq", seq_err, 0);
    chk("full_starts", starts, 1);
    chk("full_stops", stops, 1);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_idle_busy", busy, 0);
    chk("full_idle_counter", pts_counter, 0);
    chk("full_idle_cycle", pts_cycle, 0);

    // address NACK
    run_xfer(7'h50, 3'b110, -1, lat);
    chk("anack_latency", lat, 176);
    chk("anack_ack_err", ack_err, 1);
    chk("anack_pts_en_clks", pe_cnt, 0);
    chk("anack_stops", stops, 1);
    chk("anack_done_cnt", done_cnt, 1);

    // data0 NACK
    run_xfer(7'h50, 3'b101, -1, lat);
    chk("d0nack_latency", lat, 320);
    chk("d0nack_ack_err", ack_err, 1);
    chk("d0nack_cyc1", cyc1_seen, 0);
    chk("d0nack_pts_en_clks", pe_cnt, 128);
    chk("d0nack_stops", stops, 1);

    // start re-pulsed while busy: ignored, address unchanged, ack_err cleared
    run_xfer(7'h50, 3'b111, 100, lat);
    chk("rep_latency", lat, 464);
    chk("rep_done_cnt", done_cnt, 1);
    chk("rep_ack_err", ack_err, 0);
    if (bytes_q.size() > 0) chk("rep_byte0", bytes_q[0], 8'hA0);
    else chk("rep_nbytes", bytes_q.size(), 3);

    // asynchronous reset mid-transfer (inside DATA0)
    ack_mask = 3'b111;
    clear_mon();
    dev_addr = 7'h50;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("pre_rst_pts_en", pts_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_scl", scl_out, 1);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_pts_en", pts_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_counter", pts_counter, 0);
    @(negedge clk);
    rst = 1'b0;

    run_xfer(7'h50, 3'b111, -1, lat);
    chk("post_rst_latency", lat, 464);
    chk("post_rst_nbytes", bytes_q.size(), 3);
    if (bytes_q.size() == 3) chk("post_rst_byte2", bytes_q[2], 8'hA5);
    chk("post_rst_ack_err", ack_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
